// File: rtl/wm8731_i2c_responder.sv
// WM8731 2-wire control-port responder: ACKs 3-byte write packets and keeps a register shadow.
// Define WM8731_RESP_GLITCH_FILT_EN to add a FILT_LEN-sample stability filter on SCL/SDA.
//
// state        | meaning
// ST_IDLE      | bus ignored until START
// ST_ADDR      | shifting in address byte
// ST_ADDR_ACK  | driving ACK for matching write address
// ST_BYTE1     | shifting in byte1 (reg addr + data MSB)
// ST_ACK1      | driving ACK for byte1
// ST_BYTE2     | shifting in byte2 (data LSBs)
// ST_ACK2      | driving ACK for byte2, commit at its end
// ST_WAIT_STOP | packet done, extra bytes NACKed until STOP
module wm8731_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR = 7'h1A,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        reg_wr_en,
  output logic [6:0]  reg_addr,
  output logic [8:0]  reg_data,
  output logic [23:0] packet,
  input  logic [3:0]  rd_addr,
  output logic [8:0]  rd_data,
  output logic        busy,
  output logic        nack_evt
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_BYTE1, ST_ACK1, ST_BYTE2, ST_ACK2, ST_WAIT_STOP
  } state_t;

  localparam logic [8:0] REG_DEFAULTS [0:9] = '{
    9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
  };

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_f, sda_f;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

`ifdef WM8731_RESP_GLITCH_FILT_EN
  localparam int unsigned FCW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

  logic [FCW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic           scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

  // A differing level must persist for FILT_LEN consecutive samples before it is taken.
  always_comb begin
    scl_filt_d = scl_filt_q;
    scl_cnt_d  = '0;
    if (scl_sync_q[1] != scl_filt_q) begin
      if (scl_cnt_q == FCW'(FILT_LEN - 1)) scl_filt_d = scl_sync_q[1];
      else                                 scl_cnt_d  = scl_cnt_q + 1'b1;
    end
    sda_filt_d = sda_filt_q;
    sda_cnt_d  = '0;
    if (sda_sync_q[1] != sda_filt_q) begin
      if (sda_cnt_q == FCW'(FILT_LEN - 1)) sda_filt_d = sda_sync_q[1];
      else                                 sda_cnt_d  = sda_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
    end else begin
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
    end
  end

  assign scl_f = scl_filt_q;
  assign sda_f = sda_filt_q;
`else
  logic unused_filt_len;
  assign unused_filt_len = ^FILT_LEN;
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  logic scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  addr_byte_q, addr_byte_d;
  logic [7:0]  byte1_q, byte1_d;
  logic        sda_oe_q, sda_oe_d;
  logic        reg_wr_en_q, reg_wr_en_d;
  logic [6:0]  reg_addr_q, reg_addr_d;
  logic [8:0]  reg_data_q, reg_data_d;
  logic [23:0] packet_q, packet_d;
  logic        nack_evt_q, nack_evt_d;
  logic        busy_q, busy_d;
  logic [8:0]  shadow_q [0:9];
  logic [8:0]  shadow_d [0:9];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    addr_byte_d = addr_byte_q;
    byte1_d     = byte1_q;
    sda_oe_d    = sda_oe_q;
    reg_wr_en_d = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    packet_d    = packet_q;
    nack_evt_d  = 1'b0;
    shadow_d    = shadow_q;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_BYTE1, ST_BYTE2: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shreg_d   = {shreg_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (state_q == ST_ADDR) begin
              // Reads (R/W=1) and foreign addresses are both rejected here.
              if (shreg_q == {DEV_ADDR, 1'b0}) begin
                addr_byte_d = shreg_q;
                sda_oe_d    = 1'b1;
                state_d     = ST_ADDR_ACK;
              end else begin
                nack_evt_d = 1'b1;
                state_d    = ST_IDLE;
              end
            end else if (state_q == ST_BYTE1) begin
              byte1_d  = shreg_q;
              sda_oe_d = 1'b1;
              state_d  = ST_ACK1;
            end else begin
              sda_oe_d = 1'b1;
              state_d  = ST_ACK2;
            end
          end
        end
        ST_ADDR_ACK, ST_ACK1, ST_ACK2: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            case (state_q)
              ST_ADDR_ACK: state_d = ST_BYTE1;
              ST_ACK1:     state_d = ST_BYTE2;
              default: begin
                state_d     = ST_WAIT_STOP;
                reg_wr_en_d = 1'b1;
                reg_addr_d  = byte1_q[7:1];
                reg_data_d  = {byte1_q[0], shreg_q};
                packet_d    = {addr_byte_q, byte1_q, shreg_q};
                if (byte1_q[7:1] == 7'h0F) begin
                  shadow_d = REG_DEFAULTS;
                end else if (byte1_q[7:1] <= 7'd9) begin
                  shadow_d[byte1_q[4:1]] = {byte1_q[0], shreg_q};
                end
              end
            endcase
          end
        end
        ST_WAIT_STOP: begin
          // bit_cnt 9 marks the master's ACK clock of a NACKed trailing byte.
          if (scl_rise && bit_cnt_q < 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            nack_evt_d = 1'b1;
            bit_cnt_d  = 4'd9;
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            bit_cnt_d = 4'd0;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 8'd0;
      addr_byte_q <= 8'd0;
      byte1_q     <= 8'd0;
      sda_oe_q    <= 1'b0;
      reg_wr_en_q <= 1'b0;
      reg_addr_q  <= 7'd0;
      reg_data_q  <= 9'd0;
      packet_q    <= 24'd0;
      nack_evt_q  <= 1'b0;
      busy_q      <= 1'b0;
      shadow_q    <= REG_DEFAULTS;
    end else begin
      scl_prev_q  <= scl_f;
      sda_prev_q  <= sda_f;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      addr_byte_q <= addr_byte_d;
      byte1_q     <= byte1_d;
      sda_oe_q    <= sda_oe_d;
      reg_wr_en_q <= reg_wr_en_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      packet_q    <= packet_d;
      nack_evt_q  <= nack_evt_d;
      busy_q      <= busy_d;
      shadow_q    <= shadow_d;
    end
  end

  always_comb begin
    rd_data = 9'd0;
    if (rd_addr <= 4'd9) rd_data = shadow_q[rd_addr];
  end

  assign sda_oe    = sda_oe_q;
  assign reg_wr_en = reg_wr_en_q;
  assign reg_addr  = reg_addr_q;
  assign reg_data  = reg_data_q;
  assign packet    = packet_q;
  assign nack_evt  = nack_evt_q;
  assign busy      = busy_q;

endmodule
